seq110_frame_tx: RTL and testbench

//   Transmit side of the serial "110" sync link. Accepts a parallel payload word

---
 rtl/seq110_pkg.sv | 31 +++
 rtl/seq110_piso.sv | 32 +++
 rtl/seq110_frame_tx.sv | 150 +++++++++++++++
 tb/tb_seq110_frame_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seq110_pkg.sv
// Shared definitions for the "110" sync link (transmitter and receiver).
package seq110_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } tx_state_t;

  localparam logic [2:0] SEQ110_PREAMBLE = 3'b110;
  localparam int         SEQ110_PRE_LEN  = 3;

  // Counter width for a count of n states; never narrower than one bit.
  function automatic int seq110_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Preamble bit for position idx, sent MSB of the preamble first.
  function automatic logic seq110_pre_bit(input logic [1:0] idx);
    logic b;
    case (idx)
      2'd0:    b = SEQ110_PREAMBLE[2];
      2'd1:    b = SEQ110_PREAMBLE[1];
      2'd2:    b = SEQ110_PREAMBLE[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/seq110_piso.sv
// Parallel-in serial-out register: load a word, shift left, MSB presented on msb.
module seq110_piso
  import seq110_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic              msb
);

  logic [DATA_W-1:0] r_sr;

  // Load has priority over shift; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (load) begin
      r_sr <= d;
    end else if (shift) begin
      r_sr <= r_sr << 1;
    end else begin
      r_sr <= r_sr;
    end
  end

  assign msb = r_sr[DATA_W-1];

endmodule

// File: rtl/seq110_frame_tx.sv
// Serial "110" frame transmitter: preamble 1,1,0, payload MSB first, then idle gap zeros.
module seq110_frame_tx
  import seq110_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int PRE_CW  = seq110_cnt_w(SEQ110_PRE_LEN);
  localparam int DATA_CW = seq110_cnt_w(DATA_W);
  localparam int GAP_CW  = seq110_cnt_w(GAP_BITS);

  localparam logic [PRE_CW-1:0]  PRE_LAST  = PRE_CW'(SEQ110_PRE_LEN - 1);
  localparam logic [DATA_CW-1:0] DATA_LAST = DATA_CW'(DATA_W - 1);
  localparam logic [GAP_CW-1:0]  GAP_LAST  = GAP_CW'(GAP_BITS - 1);

  if (DATA_W < 1) begin : g_data_w_chk
    $error("seq110_frame_tx: DATA_W must be >= 1");
  end
  if (GAP_BITS < 1) begin : g_gap_chk
    $error("seq110_frame_tx: GAP_BITS must be >= 1");
  end

  tx_state_t          r_state;
  tx_state_t          w_next;
  logic [PRE_CW-1:0]  r_pre_cnt;
  logic [PRE_CW-1:0]  w_pre_cnt_nxt;
  logic [DATA_CW-1:0] r_data_cnt;
  logic [DATA_CW-1:0] w_data_cnt_nxt;
  logic [GAP_CW-1:0]  r_gap_cnt;
  logic [GAP_CW-1:0]  w_gap_cnt_nxt;
  logic               r_rdy_en;
  logic               r_out;
  logic               r_busy;
  logic               r_done;
  logic               w_accept;
  logic               w_load;
  logic               w_shift;
  logic               w_msb;
  logic               w_out_nxt;
  logic               w_done_nxt;

  // r_rdy_en keeps in_ready low through reset and until the first edge after release.
  assign in_ready   = r_rdy_en && (r_state == IDLE);
  assign w_accept   = in_valid && in_ready;
  assign out        = r_out;
  assign tx_busy    = r_busy;
  assign frame_done = r_done;

  seq110_piso #(
    .DATA_W (DATA_W)
  ) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .shift (w_shift),
    .d     (in_data),
    .msb   (w_msb)
  );

  // State, counters and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pre_cnt  <= '0;
      r_data_cnt <= '0;
      r_gap_cnt  <= '0;
      r_rdy_en   <= 1'b0;
      r_out      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_pre_cnt  <= w_pre_cnt_nxt;
      r_data_cnt <= w_data_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_rdy_en   <= 1'b1;
      r_out      <= w_out_nxt;
      r_busy     <= (r_state != IDLE);
      r_done     <= w_done_nxt;
    end
  end

  // Next state; the bit for the current state is registered onto the line one edge later.
  always_comb begin
    w_next         = r_state;
    w_pre_cnt_nxt  = r_pre_cnt;
    w_data_cnt_nxt = r_data_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_out_nxt      = 1'b0;
    w_done_nxt     = 1'b0;
    w_load         = 1'b0;
    w_shift        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next        = PRE;
          w_load        = 1'b1;
          w_pre_cnt_nxt = '0;
        end else begin
          w_next = IDLE;
        end
      end
      PRE: begin
        w_out_nxt = seq110_pre_bit(r_pre_cnt);
        if (r_pre_cnt == PRE_LAST) begin
          w_next         = DATA;
          w_pre_cnt_nxt  = '0;
          w_data_cnt_nxt = '0;
        end else begin
          w_pre_cnt_nxt = r_pre_cnt + PRE_CW'(1);
        end
      end
      DATA: begin
        w_out_nxt = w_msb;
        w_shift   = 1'b1;
        if (r_data_cnt == DATA_LAST) begin
          w_next         = GAP;
          w_data_cnt_nxt = '0;
          w_gap_cnt_nxt  = '0;
        end else begin
          w_data_cnt_nxt = r_data_cnt + DATA_CW'(1);
        end
      end
      GAP: begin
        w_out_nxt = 1'b0;
        if (r_gap_cnt == GAP_LAST) begin
          w_next        = IDLE;
          w_done_nxt    = 1'b1;
          w_gap_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_CW'(1);
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq110_frame_tx.sv
// Directed bench for seq110_frame_tx (DATA_W=8, GAP_BITS=2) with a 110 detector model on the line.
module tb_seq110_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       out;
  logic       tx_busy;
  logic       frame_done;

  int   checks = 0;
  int   errors = 0;
  int   det_st;
  logic det_hit;
  int   det_cnt;

  always #5 clk = ~clk;

  seq110_frame_tx #(
    .DATA_W   (8),
    .GAP_BITS (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out        (out),
    .tx_busy    (tx_busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Overlapping Mealy 110 detector: 0 = none, 1 = seen 1, 2 = seen 11.
  task automatic det_feed(input logic b);
    det_hit = (det_st == 2) && !b;
    case (det_st)
      0:       det_st = b ? 1 : 0;
      1:       det_st = b ? 2 : 0;
      default: det_st = b ? 2 : 0;
    endcase
    if (det_hit) det_cnt++;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic start_frame(input logic [7:0] d, input bit hold);
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    tick();
    chk("acc_ready", 32'(in_ready), 32'd0);
    chk("acc_busy", 32'(tx_busy), 32'd0);
    chk("acc_out", 32'(out), 32'd0);
    in_data = ~d;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic frame_check(input logic [7:0] d, input int pulse_k, input bit use_det);
    logic [12:0] exp_bits;
    exp_bits = {3'b110, d, 2'b00};
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk($sformatf("out k=%0d", k), 32'(out), 32'(exp_bits[13-k]));
      chk($sformatf("frame_done k=%0d", k), 32'(frame_done), 32'(k == 13));
      chk($sformatf("tx_busy k=%0d", k), 32'(tx_busy), 32'd1);
      chk($sformatf("in_ready k=%0d", k), 32'(in_ready), 32'(k == 13));
      if (use_det) begin
        det_feed(out);
        chk($sformatf("det_hit k=%0d", k), 32'(det_hit), 32'(k == 3));
      end
      if (pulse_k > 0 && k == pulse_k - 1) begin
        in_valid = 1'b1;
        in_data  = 8'h3C;
      end
      if (pulse_k > 0 && k == pulse_k) in_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    det_st   = 0;
    det_hit  = 1'b0;
    det_cnt  = 0;

    // Reset held with in_valid high
    repeat (3) begin
      tick();
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rel_ready_pre_edge", 32'(in_ready), 32'd0);
    tick();
    chk("rel_ready_post_edge", 32'(in_ready), 32'd1);

    // Single frame A5
    start_frame(8'hA5, 1'b0);
    frame_check(8'hA5, 0, 1'b0);
    tick();
    chk("a5_idle_out", 32'(out), 32'd0);
    chk("a5_idle_busy", 32'(tx_busy), 32'd0);
    chk("a5_idle_ready", 32'(in_ready), 32'd1);

    // Back-to-back FF then 00 with in_valid held
    start_frame(8'hFF, 1'b1);
    in_data = 8'h00;
    frame_check(8'hFF, 0, 1'b0);
    tick();
    chk("b2b_accept_ready", 32'(in_ready), 32'd0);
    chk("b2b_accept_busy", 32'(tx_busy), 32'd0);
    chk("b2b_accept_out", 32'(out), 32'd0);
    in_data = 8'hAA;
    frame_check(8'h00, 0, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("b2b_end_busy", 32'(tx_busy), 32'd0);
    chk("b2b_end_ready", 32'(in_ready), 32'd1);

    // in_valid pulsed mid-frame is ignored
    start_frame(8'hA5, 1'b0);
    frame_check(8'hA5, 5, 1'b0);
    repeat (6) begin
      tick();
      chk("nopulse_out", 32'(out), 32'd0);
      chk("nopulse_busy", 32'(tx_busy), 32'd0);
      chk("nopulse_ready", 32'(in_ready), 32'd1);
    end

    // Reset in the middle of the payload
    start_frame(8'hA5, 1'b0);
    repeat (6) tick();
    chk("midrst_before_out", 32'(out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 32'(out), 32'd0);
    chk("midrst_busy", 32'(tx_busy), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_rel_ready", 32'(in_ready), 32'd1);
    repeat (16) begin
      tick();
      chk("midrst_no_done", 32'(frame_done), 32'd0);
      chk("midrst_idle_out", 32'(out), 32'd0);
    end

    // Loopback into the 110 detector, payload 00, four frames
    det_st  = 0;
    det_cnt = 0;
    start_frame(8'h00, 1'b1);
    in_data = 8'h00;
    for (int f = 0; f < 4; f++) begin
      frame_check(8'h00, 0, 1'b1);
      if (f < 3) begin
        tick();
        det_feed(out);
        chk("loop_gap_hit", 32'(det_hit), 32'd0);
        chk("loop_accept_ready", 32'(in_ready), 32'd0);
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("loop_det_count", 32'(det_cnt), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
